// File: rtl/digit_frame_pkg.sv
// Shared constants, types and sizing helper for the digit frame scheduler.
package digit_frame_pkg;

  localparam int unsigned GLYPH_WIDTH = 21;
  localparam int unsigned GLYPH_PAGES = 4;

  typedef bit [6:0] segments_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Pixel bytes emitted for one page row: glyphs plus inter-digit gaps.
  function automatic int unsigned bytes_per_page(input int unsigned num_digits,
                                                 input int unsigned gap);
    return num_digits * GLYPH_WIDTH + (num_digits - 1) * gap;
  endfunction

endpackage

// File: rtl/digit_frame_scheduler.sv
// Walks page/digit/column over a snapshot of segment codes, drives the glyph
// decoder and streams its pixel bytes out over a valid/ready handshake.
module digit_frame_scheduler
  import digit_frame_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned GAP_COLUMNS = 3
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    start_in,
  input  logic [NUM_DIGITS*7-1:0] digits_segments_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [6:0]              dec_segments_out,
  output logic [4:0]              dec_index_x_out,
  output logic [1:0]              dec_index_y_out,
  input  logic [7:0]              dec_pixels_in,
  output logic [7:0]              data_out,
  output logic                    data_valid_out,
  input  logic                    data_ready_in
);

  localparam int unsigned DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned COL_W   = 5;
  localparam int unsigned SNAP_W  = NUM_DIGITS * 7;

  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [COL_W-1:0]   GLYPH_LAST = COL_W'(GLYPH_WIDTH - 1);
  localparam logic [COL_W-1:0]   GAP_LAST   = COL_W'(GLYPH_WIDTH - 1 + GAP_COLUMNS);
  localparam logic [1:0]         LAST_PAGE  = 2'(GLYPH_PAGES - 1);

  state_t              r_state, w_state;
  logic [SNAP_W-1:0]   r_snap, w_snap;
  logic [1:0]          r_page, w_page;
  logic [DIGIT_W-1:0]  r_digit, w_digit;
  logic [COL_W-1:0]    r_col, w_col;
  segments_t           r_dec_seg, w_dec_seg;
  logic [COL_W-1:0]    r_dec_x, w_dec_x;
  logic [7:0]          r_data, w_data;
  logic                r_valid, w_valid;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_last, w_last;

  logic [1:0]          w_adv_page;
  logic [DIGIT_W-1:0]  w_adv_digit;
  logic [COL_W-1:0]    w_adv_col;
  logic [COL_W-1:0]    w_col_last;
  logic                w_adv_glyph;
  segments_t           w_adv_seg;
  logic                w_at_end;
  logic [7:0]          w_cur_byte;

  // Fetch position r_page/r_digit/r_col is the byte currently presented to the decoder.
  assign w_col_last  = (r_digit == LAST_DIGIT) ? GLYPH_LAST : GAP_LAST;
  assign w_at_end    = (r_page == LAST_PAGE) && (r_digit == LAST_DIGIT) && (r_col == GLYPH_LAST);
  assign w_cur_byte  = (r_col <= GLYPH_LAST) ? dec_pixels_in : 8'h00;
  assign w_adv_glyph = (w_adv_col <= GLYPH_LAST);
  assign w_adv_seg   = w_adv_glyph ? segments_t'(r_snap[int'(w_adv_digit)*7 +: 7]) : segments_t'(0);

  always_comb begin
    w_adv_page  = r_page;
    w_adv_digit = r_digit;
    w_adv_col   = r_col + COL_W'(1);
    if (r_col >= w_col_last) begin
      w_adv_col = '0;
      if (r_digit == LAST_DIGIT) begin
        w_adv_digit = '0;
        w_adv_page  = r_page + 2'd1;
      end else begin
        w_adv_digit = r_digit + DIGIT_W'(1);
      end
    end
  end

  always_comb begin
    w_state   = r_state;
    w_snap    = r_snap;
    w_page    = r_page;
    w_digit   = r_digit;
    w_col     = r_col;
    w_dec_seg = r_dec_seg;
    w_dec_x   = r_dec_x;
    w_data    = r_data;
    w_valid   = r_valid;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_last    = r_last;
    case (r_state)
      IDLE: begin
        // A start coinciding with the done pulse is dropped, not queued.
        if (start_in && !r_done) begin
          w_snap    = digits_segments_in;
          w_page    = '0;
          w_digit   = '0;
          w_col     = '0;
          w_dec_seg = segments_t'(digits_segments_in[6:0]);
          w_dec_x   = '0;
          w_busy    = 1'b1;
          w_state   = LOAD;
        end
      end
      LOAD: begin
        w_data    = w_cur_byte;
        w_valid   = 1'b1;
        w_last    = w_at_end;
        w_page    = w_adv_page;
        w_digit   = w_adv_digit;
        w_col     = w_adv_col;
        w_dec_seg = w_adv_seg;
        w_dec_x   = w_adv_glyph ? w_adv_col : '0;
        w_state   = STREAM;
      end
      STREAM: begin
        if (r_valid && data_ready_in) begin
          if (r_last) begin
            w_valid   = 1'b0;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_last    = 1'b0;
            w_page    = '0;
            w_digit   = '0;
            w_col     = '0;
            w_dec_seg = '0;
            w_dec_x   = '0;
            w_state   = IDLE;
          end else begin
            w_data    = w_cur_byte;
            w_last    = w_at_end;
            w_page    = w_adv_page;
            w_digit   = w_adv_digit;
            w_col     = w_adv_col;
            w_dec_seg = w_adv_seg;
            w_dec_x   = w_adv_glyph ? w_adv_col : '0;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state   <= IDLE;
      r_snap    <= '0;
      r_page    <= '0;
      r_digit   <= '0;
      r_col     <= '0;
      r_dec_seg <= '0;
      r_dec_x   <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_snap    <= w_snap;
      r_page    <= w_page;
      r_digit   <= w_digit;
      r_col     <= w_col;
      r_dec_seg <= w_dec_seg;
      r_dec_x   <= w_dec_x;
      r_data    <= w_data;
      r_valid   <= w_valid;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_last    <= w_last;
    end
  end

  assign busy_out         = r_busy;
  assign done_out         = r_done;
  assign dec_segments_out = r_dec_seg;
  assign dec_index_x_out  = r_dec_x;
  assign dec_index_y_out  = r_page;
  assign data_out         = r_data;
  assign data_valid_out   = r_valid;

endmodule

// File: tb/tb_digit_frame_scheduler.sv
// Bench for digit_frame_scheduler with a behavioural glyph decoder alongside it.
module tb_digit_frame_scheduler;

  localparam int ND    = 5;
  localparam int GAP   = 3;
  localparam int BPP   = ND * 21 + (ND - 1) * GAP;
  localparam int FRAME = 4 * BPP;
  localparam int SEGW  = ND * 7;

  logic            clk_in = 1'b0;
  logic            reset_n_in;
  logic            start_in;
  logic [SEGW-1:0] digits_segments_in;
  logic            busy_out;
  logic            done_out;
  logic [6:0]      dec_segments_out;
  logic [4:0]      dec_index_x_out;
  logic [1:0]      dec_index_y_out;
  logic [7:0]      dec_pixels_in;
  logic [7:0]      data_out;
  logic            data_valid_out;
  logic            data_ready_in;

  always #5 clk_in = ~clk_in;

  digit_frame_scheduler #(.NUM_DIGITS(ND), .GAP_COLUMNS(GAP)) dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .start_in           (start_in),
    .digits_segments_in (digits_segments_in),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .dec_segments_out   (dec_segments_out),
    .dec_index_x_out    (dec_index_x_out),
    .dec_index_y_out    (dec_index_y_out),
    .dec_pixels_in      (dec_pixels_in),
    .data_out           (data_out),
    .data_valid_out     (data_valid_out),
    .data_ready_in      (data_ready_in)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int done_cyc, done_cnt, first_valid_cyc, stall_viol;
  bit timed_out;

  // 21x32 seven-segment glyph: 3-pixel strokes, g bar on rows 15-16.
  function automatic bit pix(input logic [6:0] s, input int x, input int r);
    bit v;
    v = 1'b0;
    if (s[0] && r <= 2 && x >= 3 && x <= 17)               v = 1'b1;
    if (s[1] && x >= 18 && x <= 20 && r >= 3 && r <= 14)   v = 1'b1;
    if (s[2] && x >= 18 && x <= 20 && r >= 17 && r <= 28)  v = 1'b1;
    if (s[3] && r >= 29 && x >= 3 && x <= 17)              v = 1'b1;
    if (s[4] && x <= 2 && r >= 17 && r <= 28)              v = 1'b1;
    if (s[5] && x <= 2 && r >= 3 && r <= 14)               v = 1'b1;
    if (s[6] && (r == 15 || r == 16) && x >= 3 && x <= 17) v = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] glyph_byte(input logic [6:0] s, input int x, input int y);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = pix(s, x, 8 * y + k);
    return b;
  endfunction

  always_comb dec_pixels_in = glyph_byte(dec_segments_out, int'(dec_index_x_out), int'(dec_index_y_out));

  function automatic void build_exp(input logic [SEGW-1:0] segs);
    logic [6:0] s;
    exp_q.delete();
    for (int p = 0; p < 4; p++)
      for (int d = 0; d < ND; d++) begin
        s = segs[d*7 +: 7];
        for (int x = 0; x < 21; x++) exp_q.push_back(glyph_byte(s, x, p));
        if (d < ND - 1) for (int g = 0; g < GAP; g++) exp_q.push_back(8'h00);
      end
  endfunction

  // mode 0: ready held high; mode 1: planned stalls plus random ready.
  // action 1: restart + new digits at ev_byte; 2: reset at ev_byte; 3: start during done.
  task automatic run_frame(input logic [SEGW-1:0] segs, input int mode,
                           input int ev_byte, input int action);
    int cyc, n, stall_left;
    bit s10, s116, s117, fired, prev_stall, rdy;
    logic [7:0] prev_data;
    got.delete();
    done_cyc = -1; done_cnt = 0; first_valid_cyc = -1; stall_viol = 0; timed_out = 0;
    cyc = 0; n = 0; stall_left = 0; s10 = 0; s116 = 0; s117 = 0; fired = 0;
    prev_stall = 0; prev_data = 8'h00;
    @(negedge clk_in);
    digits_segments_in = segs;
    start_in = 1'b1;
    while (1) begin
      @(negedge clk_in);
      cyc++;
      start_in = 1'b0;
      if (first_valid_cyc < 0 && data_valid_out) first_valid_cyc = cyc;
      if (prev_stall && (data_out !== prev_data || data_valid_out !== 1'b1)) stall_viol++;
      if (done_out) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (action == 3) start_in = 1'b1;
      end
      if (mode == 1 && data_valid_out) begin
        if (n == 10 && !s10)   begin stall_left = 5; s10 = 1; end
        if (n == 116 && !s116) begin stall_left = 1; s116 = 1; end
        if (n == 117 && !s117) begin stall_left = 1; s117 = 1; end
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      data_ready_in = rdy;
      prev_stall = data_valid_out && !rdy;
      prev_data  = data_out;
      if (data_valid_out && rdy) begin
        got.push_back(data_out);
        n++;
      end
      if (!fired && ev_byte >= 0 && n == ev_byte) begin
        fired = 1;
        if (action == 1) begin
          start_in = 1'b1;
          digits_segments_in = ~segs;
        end else if (action == 2) begin
          reset_n_in = 1'b0;
          return;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc > 4000) begin timed_out = 1; break; end
    end
    data_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0; start_in = 1'b0; data_ready_in = 1'b0; digits_segments_in = '0;
    repeat (3) @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      n_checks++;
      if ({data_valid_out, done_out, busy_out} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: valid/done/busy=%b expected 000", i,
                 {data_valid_out, done_out, busy_out});
      end
    end
    n_checks++;
    if ({data_out, dec_segments_out, dec_index_x_out, dec_index_y_out} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_values: data=%h seg=%h x=%0d y=%0d expected all 0",
               data_out, dec_segments_out, dec_index_x_out, dec_index_y_out);
    end
  endtask

  task automatic check_stream(input string name);
    n_checks++;
    if (timed_out) begin n_err++; $display("FAIL %s timeout: no done within budget", name); end
    n_checks++;
    if (got.size() !== FRAME) begin
      n_err++;
      $display("FAIL %s count: got %0d bytes expected %0d", name, got.size(), FRAME);
    end
    for (int i = 0; i < FRAME && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s byte %0d: got %h expected %h", name, i, got[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
  endtask

  task automatic test_zero_frame();
    build_exp('0);
    run_frame('0, 0, -1, 0);
    check_stream("zero_frame");
    n_checks++;
    if (first_valid_cyc !== 2) begin
      n_err++; $display("FAIL first_valid_latency: got %0d expected 2", first_valid_cyc);
    end
    n_checks++;
    if (done_cyc !== 2 + FRAME) begin
      n_err++; $display("FAIL done_latency: got %0d expected %0d", done_cyc, 2 + FRAME);
    end
    n_checks++;
    if (busy_out !== 1'b0 || data_valid_out !== 1'b0) begin
      n_err++; $display("FAIL zero_after_done: busy=%b valid=%b expected 0 0", busy_out, data_valid_out);
    end
  endtask

  task automatic test_all_on();
    logic [SEGW-1:0] segs;
    int idx;
    segs = '1;
    build_exp(segs);
    run_frame(segs, 0, -1, 0);
    check_stream("all_on");
    for (int p = 0; p < 4; p++)
      for (int d = 0; d < ND - 1; d++)
        for (int g = 0; g < GAP; g++) begin
          idx = p * BPP + d * (21 + GAP) + 21 + g;
          if (idx < got.size()) begin
            n_checks++;
            if (got[idx] !== 8'h00) begin
              n_err++; $display("FAIL gap_column page %0d col %0d: got %h expected 00", p, idx - p * BPP, got[idx]);
            end
          end
        end
  endtask

  task automatic test_backpressure();
    logic [SEGW-1:0] segs;
    for (int r = 0; r < 2; r++) begin
      segs = SEGW'({$urandom(), $urandom()});
      build_exp(segs);
      run_frame(segs, 1, -1, 0);
      check_stream("backpressure");
      n_checks++;
      if (stall_viol !== 0) begin
        n_err++; $display("FAIL stall_stability: got %0d changes expected 0", stall_viol);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [SEGW-1:0] segs;
    segs = SEGW'({$urandom(), $urandom()});
    build_exp(segs);
    run_frame(segs, 0, 50, 1);
    check_stream("start_ignored");
  endtask

  task automatic test_reset_mid_frame();
    logic [SEGW-1:0] segs;
    int dones;
    segs = SEGW'({$urandom(), $urandom()});
    run_frame(segs, 0, 200, 2);
    #1;
    n_checks++;
    if ({data_valid_out, busy_out, done_out, data_out} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear: valid=%b busy=%b done=%b data=%h expected 0", data_valid_out,
               busy_out, done_out, data_out);
    end
    dones = 0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      if (done_out) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_err++; $display("FAIL reset_mid_done: got %0d pulses expected 0", dones); end
    segs = SEGW'({$urandom(), $urandom()});
    build_exp(segs);
    run_frame(segs, 0, -1, 0);
    check_stream("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [SEGW-1:0] segs;
    segs = SEGW'({$urandom(), $urandom()});
    build_exp(segs);
    run_frame(segs, 0, -1, 3);
    check_stream("start_on_done");
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_err++; $display("FAIL start_on_done_busy: got %b expected 0", busy_out);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_all_on();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
